// File: rtl/cordic_pkg.sv
// Shared constants, angle table and state encoding for the vectoring-mode CORDIC engine.
package cordic_pkg;

    localparam int FRAC     = 16;
    localparam int PI_HALF  = 102944;
    localparam int PI       = 205887;
    localparam int ATAN_LEN = 16;

    // round(atan(2^-i) * 2^16)
    localparam int ATAN_TABLE [ATAN_LEN] = '{
        51472, 30386, 16055, 8150, 4091, 2047, 1024, 512,
        256,   128,   64,    32,   16,   8,    4,    2
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        ROT  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Rescale a 2^-16 constant to a different fractional width.
    function automatic longint scale_frac(input int v, input int frac);
        if (frac >= 16) begin
            return longint'(v) <<< (frac - 16);
        end
        return longint'(v) >>> (16 - frac);
    endfunction

endpackage

// File: rtl/cordic_vector_iter_if.sv
// Input-vector and result handshake bundle of the vectoring CORDIC engine.
interface cordic_vector_iter_if #(
    parameter int W = 32
);
    logic signed [W-1:0] x_in;
    logic signed [W-1:0] y_in;
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] mag_out;
    logic signed [W-1:0] angle_out;
    logic                out_valid;
    logic                out_ready;

    modport master (
        output x_in, y_in, in_valid, out_ready,
        input  in_ready, mag_out, angle_out, out_valid
    );

    modport slave (
        input  x_in, y_in, in_valid, out_ready,
        output in_ready, mag_out, angle_out, out_valid
    );
endinterface

// File: rtl/cordic_atan_rom.sv
// Combinational micro-rotation angle lookup, sign-extended to the internal datapath width.
module cordic_atan_rom
    import cordic_pkg::*;
#(
    parameter int W    = 32,
    parameter int FRAC = 16
) (
    input  logic [4:0]          idx_i,
    output logic signed [W+1:0] atan_o
);

    logic signed [W+1:0] table_w [ATAN_LEN];

    genvar gi;
    generate
        for (gi = 0; gi < ATAN_LEN; gi++) begin : g_tab
            assign table_w[gi] = (W+2)'(scale_frac(ATAN_TABLE[gi], FRAC));
        end
    endgenerate

    assign atan_o = (idx_i < 5'(ATAN_LEN)) ? table_w[idx_i[3:0]] : '0;

endmodule

// File: rtl/cordic_vector_iter.sv
// Iterative vectoring-mode CORDIC: rotates (x,y) onto the +x axis over ITER cycles,
// returning K*|v| and atan2(y,x) through valid/ready handshakes.
module cordic_vector_iter
    import cordic_pkg::*;
#(
    parameter int ITER = 16,
    parameter int W    = 32,
    parameter int FRAC = 16
) (
    input  logic               clk,
    input  logic               rst,
    cordic_vector_iter_if.slave bus
);

    localparam int XW = W + 2;
    localparam logic signed [XW-1:0] PI_HALF_S = XW'(scale_frac(PI_HALF, FRAC));

    state_t              state_q, state_d;
    logic signed [XW-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic [4:0]          cnt_q, cnt_d;
    logic                zero_q, zero_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic signed [W-1:0] mag_q, mag_d;
    logic signed [W-1:0] angle_q, angle_d;

    logic signed [XW-1:0] atan_w, x_sh, y_sh, x_rot, y_rot, z_rot;
    logic                 y_pos_w, last_w;

    function automatic logic signed [W-1:0] sat_mag(input logic signed [XW-1:0] v);
        if (v[XW-1:W-1] == {(XW-W+1){v[W-1]}}) begin
            return v[W-1:0];
        end
        return v[XW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    endfunction

    cordic_atan_rom #(
        .W    (W),
        .FRAC (FRAC)
    ) u_rom (
        .idx_i  (cnt_q),
        .atan_o (atan_w)
    );

    // One micro-rotation; both updates use the pre-update x and y.
    assign x_sh    = x_q >>> cnt_q;
    assign y_sh    = y_q >>> cnt_q;
    assign y_pos_w = ~y_q[XW-1] & (|y_q);
    assign x_rot   = y_pos_w ? x_q + y_sh   : x_q - y_sh;
    assign y_rot   = y_pos_w ? y_q - x_sh   : y_q + x_sh;
    assign z_rot   = y_pos_w ? z_q + atan_w : z_q - atan_w;
    assign last_w  = (cnt_q == 5'(ITER - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            cnt_q       <= '0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            mag_q       <= '0;
            angle_q     <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            cnt_q       <= cnt_d;
            zero_q      <= zero_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            mag_q       <= mag_d;
            angle_q     <= angle_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid && in_ready_q) state_d = PRE;
            PRE:     state_d = ROT;
            ROT:     if (last_w) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        cnt_d       = cnt_q;
        zero_d      = zero_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        mag_d       = mag_q;
        angle_d     = angle_q;
        case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                if (bus.in_valid && in_ready_q) begin
                    x_d        = XW'(bus.x_in);
                    y_d        = XW'(bus.y_in);
                    z_d        = '0;
                    zero_d     = (bus.x_in == '0) && (bus.y_in == '0);
                    in_ready_d = 1'b0;
                end
            end
            PRE: begin
                // Fold the left half-plane into the CORDIC convergence range.
                if (x_q[XW-1]) begin
                    if (!y_q[XW-1]) begin
                        x_d = y_q;
                        y_d = -x_q;
                        z_d = PI_HALF_S;
                    end else begin
                        x_d = -y_q;
                        y_d = x_q;
                        z_d = -PI_HALF_S;
                    end
                end
                cnt_d = '0;
            end
            ROT: begin
                x_d   = x_rot;
                y_d   = y_rot;
                z_d   = z_rot;
                cnt_d = cnt_q + 5'd1;
                if (last_w) begin
                    mag_d       = sat_mag(x_rot);
                    // A zero vector never leaves y=0, so z would drift; report 0 instead.
                    angle_d     = zero_q ? '0 : z_rot[W-1:0];
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.mag_out   = mag_q;
    assign bus.angle_out = angle_q;

endmodule

// File: tb/tb_cordic_vector_iter.sv
// Self-checking bench: floating-point atan2/hypot reference, directed literals and random traffic.
`timescale 1ns/1ps
module tb_cordic_vector_iter;

    localparam int ITER   = 16;
    localparam int W      = 32;
    localparam int FRAC   = 16;
    localparam int TOL    = 24;
    localparam int TWO_PI = 411775;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cordic_vector_iter_if #(.W(W)) bus();

    cordic_vector_iter #(
        .ITER (ITER),
        .W    (W),
        .FRAC (FRAC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic int rnd(input real r);
        return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
    endfunction

    function automatic real k_gain();
        real k = 1.0;
        real p = 1.0;
        for (int i = 0; i < ITER; i++) begin
            k = k * $sqrt(1.0 + p);
            p = p / 4.0;
        end
        return k;
    endfunction

    function automatic int model_mag(input int x, input int y);
        real rx = real'(x);
        real ry = real'(y);
        return rnd(k_gain() * $sqrt(rx * rx + ry * ry));
    endfunction

    function automatic int model_ang(input int x, input int y);
        return rnd($atan2(real'(y), real'(x)) * real'(1 << FRAC));
    endfunction

    // ---------------- comparison helpers ----------------
    task automatic chk_eq(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic chk_tol(input string name, input longint act, input longint req);
        longint d = act - req;
        checks++;
        if (d > TOL || d < -TOL) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (+/-%0d)", name, act, req, TOL);
        end
    endtask

    task automatic chk_ang(input string name, input longint act, input longint req);
        longint d = act - req;
        if (d > TWO_PI / 2) d = d - TWO_PI;
        if (d < -TWO_PI / 2) d = d + TWO_PI;
        checks++;
        if (d > TOL || d < -TOL) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (+/-%0d)", name, act, req, TOL);
        end
    endtask

    // ---------------- compare process ----------------
    int exp_mag_q [$];
    int exp_ang_q [$];
    int acc_q     [$];
    logic prev_ov = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            exp_mag_q.delete();
            exp_ang_q.delete();
            acc_q.delete();
            prev_ov = 1'b0;
        end else begin
            if (bus.out_valid) begin
                if (exp_mag_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_out_valid: got out_valid=1 expected no pending result");
                end else begin
                    if (!prev_ov) chk_eq("latency", cyc - acc_q[0], ITER + 1);
                    chk_tol("model_mag", bus.mag_out, exp_mag_q[0]);
                    chk_ang("model_angle", bus.angle_out, exp_ang_q[0]);
                    if (bus.out_ready) begin
                        void'(exp_mag_q.pop_front());
                        void'(exp_ang_q.pop_front());
                        void'(acc_q.pop_front());
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_mag_q.push_back(model_mag(bus.x_in, bus.y_in));
                exp_ang_q.push_back(model_ang(bus.x_in, bus.y_in));
                acc_q.push_back(cyc + 1);
            end
            prev_ov = bus.out_valid;
        end
    end

    // ---------------- drivers ----------------
    task automatic send(input int x, input int y, output int acc_edge);
        bus.x_in     = x;
        bus.y_in     = y;
        bus.in_valid = 1'b1;
        acc_edge     = -1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                acc_edge = cyc + 1;
                break;
            end
        end
        if (acc_edge < 0) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready=0 for 200 cycles expected accept");
        end else begin
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        $display("send x=%0d y=%0d accept_edge=%0d", x, y, acc_edge);
    endtask

    task automatic wait_result(output int m, output int a);
        m = 0;
        a = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                m = bus.mag_out;
                a = bus.angle_out;
                $display("result mag=%0d angle=%0d", m, a);
                @(posedge clk);
                #1;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL result_timeout: got out_valid=0 for 100 cycles expected result");
    endtask

    task automatic run_lit(input string name, input int x, input int y,
                           input int em, input int ea);
        int acc, m, a;
        send(x, y, acc);
        wait_result(m, a);
        chk_tol({name, "_mag"}, m, em);
        chk_ang({name, "_angle"}, a, ea);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, prev, m, a, rm, ra, x, y;
        logic got;
        bus.x_in      = 0;
        bus.y_in      = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_eq("rst_out_valid", bus.out_valid, 0);
        chk_eq("rst_in_ready", bus.in_ready, 0);
        chk_eq("rst_mag", bus.mag_out, 0);
        chk_eq("rst_angle", bus.angle_out, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_eq("rst_release_in_ready_low", bus.in_ready, 0);
        @(negedge clk);
        chk_eq("rst_release_in_ready_high", bus.in_ready, 1);
        @(posedge clk);
        #1;

        // directed literals
        run_lit("x1y0",   65536,      0, 107922,       0);
        run_lit("x0y1",       0,  65536, 107922,  102944);
        run_lit("x1y1",   65536,  65536, 152624,   51472);
        run_lit("xm1y0", -65536,      0, 107922,  205887);
        run_lit("xm1ym1",-65536, -65536, 152624, -154415);
        run_lit("zero",       0,      0,      0,       0);

        // backpressure with a vector queued during DONE
        bus.out_ready = 1'b0;
        send(65536, -65536, acc);
        got = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL bp_timeout: got out_valid=0 expected result");
        end
        rm = bus.mag_out;
        ra = bus.angle_out;
        chk_tol("bp_mag", rm, 152624);
        chk_ang("bp_angle", ra, -51472);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (k == 2) begin
                bus.x_in     = 40000;
                bus.y_in     = 30000;
                bus.in_valid = 1'b1;
            end
            @(negedge clk);
            chk_eq("bp_hold_valid", bus.out_valid, 1);
            chk_eq("bp_hold_in_ready", bus.in_ready, 0);
            chk_eq("bp_hold_mag", bus.mag_out, rm);
            chk_eq("bp_hold_angle", bus.angle_out, ra);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk_eq("bp_release_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        wait_result(m, a);
        chk_tol("queued_mag", m, 82338);
        chk_ang("queued_angle", a, 42173);

        // reset in the middle of ROT
        send(65536, 65536, acc);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_eq("midrst_out_valid", bus.out_valid, 0);
        chk_eq("midrst_in_ready", bus.in_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_eq("midrst_release_low", bus.in_ready, 0);
        @(negedge clk);
        chk_eq("midrst_release_high", bus.in_ready, 1);
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            chk_eq("midrst_no_result", bus.out_valid, 0);
        end
        @(posedge clk);
        #1;
        run_lit("after_rst", 0, 65536, 107922, 102944);

        // back-to-back random vectors
        prev = -1;
        for (int n = 0; n < 50; n++) begin
            do begin
                x = int'($urandom_range(0, 8388608)) - 4194304;
                y = int'($urandom_range(0, 8388608)) - 4194304;
            end while ((longint'(x) * x + longint'(y) * y) < 64'd268435456);
            send(x, y, acc);
            if (prev >= 0) chk_eq("spacing", acc - prev, ITER + 3);
            prev = acc;
        end
        for (int t = 0; t < 100 && exp_mag_q.size() != 0; t++) @(negedge clk);
        chk_eq("drain", exp_mag_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cordic_vector_iter.md
Name: cordic_vector_iter

Overview:
- Iterative CORDIC engine in vectoring mode. It drives y to zero and accumulates the rotation angle in z, so it returns the magnitude (gain-scaled) and atan2(y,x) of a 32-bit signed vector.
- It is the inverse direction of the rotation-mode shift-accumulate pipeline stages: those consume an angle and produce a vector; this block consumes a vector and produces an angle.
- It reuses one shift-add datapath over ITER cycles, with a valid/ready handshake on both sides.

Parameters:
- ITER, 16, number of micro-rotations (legal 1..16).
- W, 32, data/angle width in bits.
- FRAC, 16, fractional bits of all fixed-point quantities (x, y, angle in radians).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- x_in  input  W  signed x component.
- y_in  input  W  signed y component.
- in_valid  input  1  input vector valid.
- in_ready  output  1  block can accept a vector.
- mag_out  output  W  signed magnitude × K (K≈1.64676), not gain-compensated.
- angle_out  output  W  signed angle, radians, range [-pi, pi].
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.

Behaviour:
- Reset values (synchronous, rst high at a rising edge): state=IDLE; out_valid=0; mag_out=0; angle_out=0; in_ready=0 while rst is high, then 1 on the first edge after rst deasserts. Internal x, y, z and the iteration counter are cleared to 0.
- in_ready, out_valid, mag_out and angle_out are all registered outputs.
- Input constraint: |x_in|, |y_in| < 2^(W-3). The internal x/y/z registers are W+2 bits. mag_out saturates to 2^(W-1)-1 if the internal value exceeds the output range.
- FSM states: IDLE, PRE, ROT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch x_in and y_in, clear z to 0, drop in_ready, go to PRE.
- PRE (1 cycle), quadrant correction:
  - If x<0 and y>=0: x'=y, y'=-x, z=+PI_HALF.
  - If x<0 and y<0: x'=-y, y'=x, z=-PI_HALF.
  - Otherwise unchanged.
  - Set i=0, go to ROT.
- ROT (ITER cycles), iteration i:
  - If signed y>0: x+= y>>>i; y-= x>>>i; z+= ATAN[i].
  - Else: x-= y>>>i; y+= x>>>i; z-= ATAN[i].
  - All right-hand sides use the pre-update x and y. Shifts are arithmetic; add/sub wraps modulo 2^(W+2).
  - i increments each cycle. After iteration ITER-1, load mag_out=sat(x) and angle_out=z[W-1:0], set out_valid=1, go to DONE.
- DONE:
  - out_valid=1. mag_out and angle_out are held stable while out_ready=0.
  - On out_ready: out_valid=0, in_ready=1, go to IDLE.
  - in_ready stays low in DONE; there is no accept/deliver overlap.
- Latency: if the vector is accepted at edge T, out_valid is high after edge T+ITER+1.
- Throughput: one vector per ITER+3 cycles minimum with out_ready tied high.
- x=0,y=0: angle_out=0, mag_out=0. The y=0 case takes the "else" branch.
- x<0,y=0 takes the y>=0 pre-rotation, so the result is +pi, never -pi.
- rst during PRE/ROT/DONE: the in-flight result is discarded and never presented; outputs return to reset values.
- in_valid while in_ready=0 is ignored. The source must hold x_in and y_in until the handshake.

Decomposition:
- Package cordic_pkg holds:
  - FRAC.
  - PI_HALF=102944 and PI=205887 (scaled by 2^16).
  - ATAN table, entries i=0..15 = round(atan(2^-i)·2^16): 51472, 30386, 16055, 8150, 4091, 2047, 1024, 512, 256, 128, 64, 32, 16, 8, 4, 2.
  - The FSM state enum.
- One sub-module: cordic_atan_rom, a combinational index→ATAN[i] lookup, sign-extended to W+2.

Test Plan (ITER=16, FRAC=16; tolerance ±24 LSB on both outputs):
- x=65536, y=0 -> angle_out≈0, mag_out≈107922; out_valid rises exactly 17 edges after the accept edge.
- x=0, y=65536 -> angle_out≈102944, mag_out≈107922. x=65536, y=65536 -> angle_out≈51472, mag_out≈152624.
- x=-65536, y=0 -> angle_out≈205887 (+pi). x=-65536, y=-65536 -> angle_out≈-154415, mag_out≈152624.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> outputs stable, in_ready=0, a new in_valid is ignored. Raise out_ready -> in_ready=1 on the next cycle, and the queued vector is then accepted correctly.
- Reset mid-ROT (cycle 5 after accept) -> out_valid never asserts; in_ready=1 the edge after rst falls; the next vector (0, 65536) returns ≈102944.
- Back-to-back 50 random vectors with out_ready=1 -> each matches a reference atan2·2^16 and K·hypot·2^16 within tolerance; spacing is ITER+3 cycles.
